// File: rtl/noc_params.sv
// Shared NoC types: flit format, link geometry and the output-VC state encoding.
package noc_params;

  localparam int VC_NUM    = 4;
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_SIZE = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_num;
    logic [DATA_SIZE-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {OVC_IDLE, OVC_ACTIVE, OVC_DRAIN} ovc_state_t;

  function automatic logic is_tail(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/output_port_if.sv
// Crossbar-to-link flit path of one output port: crossbar side in, link side out.
interface output_port_if;
  import noc_params::*;

  flit_t xb_flit_i;
  logic  xb_valid_i;
  flit_t data_o;
  logic  valid_flit_o;

  modport master (output xb_flit_i, xb_valid_i, input data_o, valid_flit_o);
  modport slave  (input xb_flit_i, xb_valid_i, output data_o, valid_flit_o);

endinterface

// File: rtl/output_vc_state.sv
// Ownership tracker for one downstream VC: IDLE -> ACTIVE on grant, back via tail
// (and optionally a drain wait); flags protocol violations in a sticky error bit.
module output_vc_state
  import noc_params::*;
#(
  parameter bit DRAIN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flit_hit,
  input  flit_label_t flit_label,
  input  logic        grant,
  input  logic        on_off,
  input  logic        downstream_free,
  output logic        is_allocatable,
  output logic        error
);

  ovc_state_t state, next_state;
  logic       next_error;
  logic       tail_sent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OVC_IDLE;
      error <= 1'b0;
    end else begin
      state <= next_state;
      error <= next_error;
    end
  end

  // A tail wins over a colliding grant; the grant is only recorded as an error.
  always_comb begin
    next_state = state;
    next_error = error;
    tail_sent  = flit_hit && is_tail(flit_label);
    if (flit_hit && !on_off) next_error = 1'b1;
    case (state)
      OVC_IDLE: begin
        if (flit_hit) next_error = 1'b1;
        if (grant)    next_state = OVC_ACTIVE;
      end
      OVC_ACTIVE: begin
        if (grant)     next_error = 1'b1;
        if (tail_sent) next_state = DRAIN_CHECK ? OVC_DRAIN : OVC_IDLE;
      end
      OVC_DRAIN: begin
        if (grant)           next_error = 1'b1;
        if (downstream_free) next_state = OVC_IDLE;
      end
      default: next_state = OVC_IDLE;
    endcase
  end

  assign is_allocatable = (state == OVC_IDLE);

endmodule

// File: rtl/output_port.sv
// Transmit end of a router output link: registers the crossbar flit onto the link
// and tracks downstream on/off and per-VC ownership for the allocators.
module output_port
  import noc_params::*;
#(
  parameter bit DRAIN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output_port_if.slave      link,
  input  logic [VC_NUM-1:0] va_grant_i,
  input  logic [VC_NUM-1:0] on_off_i,
  input  logic [VC_NUM-1:0] vc_allocatable_i,
  output logic [VC_NUM-1:0] is_on_off_o,
  output logic [VC_NUM-1:0] is_allocatable_o,
  output logic [VC_NUM-1:0] error_o
);

  flit_t             data_q;
  logic              valid_q;
  logic [VC_NUM-1:0] on_off_q;
  logic [VC_NUM-1:0] flit_hit;

  // Downstream buffers are empty out of reset, so on/off starts as all-on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      on_off_q <= '1;
    end else begin
      valid_q  <= link.xb_valid_i;
      on_off_q <= on_off_i;
      if (link.xb_valid_i) data_q <= link.xb_flit_i;
    end
  end

  assign link.data_o       = data_q;
  assign link.valid_flit_o = valid_q;
  assign is_on_off_o       = on_off_q;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign flit_hit[v] = link.xb_valid_i && (link.xb_flit_i.vc_num == VC_SIZE'(v));

    output_vc_state #(.DRAIN_CHECK(DRAIN_CHECK)) u_vc_state (
      .clk             (clk),
      .rst             (rst),
      .flit_hit        (flit_hit[v]),
      .flit_label      (link.xb_flit_i.flit_label),
      .grant           (va_grant_i[v]),
      .on_off          (on_off_q[v]),
      .downstream_free (vc_allocatable_i[v]),
      .is_allocatable  (is_allocatable_o[v]),
      .error           (error_o[v])
    );
  end

endmodule

// File: tb/tb_output_port.sv
// Self-checking bench for output_port: flits scoreboarded through the link, VC
// state/error/on-off checked against fixed expectations; a DRAIN_CHECK=0 copy runs alongside.
module tb_output_port;
  import noc_params::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [VC_NUM-1:0] va_grant_i = '0;
  logic [VC_NUM-1:0] on_off_i = '1;
  logic [VC_NUM-1:0] vc_allocatable_i = '0;
  logic [VC_NUM-1:0] is_on_off, is_alloc, error;
  logic [VC_NUM-1:0] is_on_off_nd, is_alloc_nd, error_nd;

  int    vectors = 0;
  int    miscompares = 0;
  flit_t sb[$];
  flit_t last_flit;
  flit_t got_flit;

  output_port_if ifc();
  output_port_if ifc_nd();

  assign ifc_nd.xb_flit_i  = ifc.xb_flit_i;
  assign ifc_nd.xb_valid_i = ifc.xb_valid_i;

  output_port #(.DRAIN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .link(ifc.slave),
    .va_grant_i(va_grant_i), .on_off_i(on_off_i), .vc_allocatable_i(vc_allocatable_i),
    .is_on_off_o(is_on_off), .is_allocatable_o(is_alloc), .error_o(error)
  );

  output_port #(.DRAIN_CHECK(1'b0)) dut_nd (
    .clk(clk), .rst(rst), .link(ifc_nd.slave),
    .va_grant_i(va_grant_i), .on_off_i(on_off_i), .vc_allocatable_i(vc_allocatable_i),
    .is_on_off_o(is_on_off_nd), .is_allocatable_o(is_alloc_nd), .error_o(error_nd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle of stimulus; grant and valid are single-cycle pulses.
  task automatic applyStimulus(input logic valid, input flit_label_t label, input logic [VC_SIZE-1:0] vc,
                               input logic [DATA_SIZE-1:0] data, input logic [VC_NUM-1:0] grant);
    flit_t f;
    f.flit_label = label;
    f.vc_num     = vc;
    f.data       = data;
    ifc.xb_flit_i  = f;
    ifc.xb_valid_i = valid;
    va_grant_i     = grant;
    if (valid) begin
      sb.push_back(f);
      last_flit = f;
    end
    @(posedge clk);
    #1;
    ifc.xb_valid_i = 1'b0;
    va_grant_i     = '0;
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ifc.valid_flit_o) begin
      if (sb.size() == 0) begin
        checkOutput("link_extra_flit", 32'(ifc.data_o), 32'hFFFFFFFF);
      end else begin
        got_flit = sb.pop_front();
        checkOutput("link_data", 32'(ifc.data_o), 32'(got_flit));
      end
    end
  end

  initial begin
    ifc.xb_flit_i  = '0;
    ifc.xb_valid_i = 1'b0;
    last_flit      = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted mid-cycle with a flit on the link and an error pending.
    applyStimulus(1'b1, HEAD, 2'd0, 16'hAAAA, 4'b0000);
    checkOutput("pre_rst_valid", 32'(ifc.valid_flit_o), 32'd1);
    checkOutput("pre_rst_error", 32'(error), 32'h1);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("rst_valid", 32'(ifc.valid_flit_o), 32'd0);
    checkOutput("rst_data", 32'(ifc.data_o), 32'd0);
    checkOutput("rst_on_off", 32'(is_on_off), 32'hF);
    checkOutput("rst_alloc", 32'(is_alloc), 32'hF);
    checkOutput("rst_error", 32'(error), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full packet on VC 0 with drain check.
    applyStimulus(1'b0, HEAD, 2'd0, 16'h0, 4'b0001);
    checkOutput("pkt_alloc_grant", 32'(is_alloc), 32'hE);
    applyStimulus(1'b1, HEAD, 2'd0, 16'h1111, 4'b0000);
    applyStimulus(1'b1, BODY, 2'd0, 16'h2222, 4'b0000);
    applyStimulus(1'b1, TAIL, 2'd0, 16'h3333, 4'b0000);
    checkOutput("pkt_alloc_after_tail", 32'(is_alloc), 32'hE);
    applyStimulus(1'b0, BODY, 2'd0, 16'h0, 4'b0000);
    checkOutput("idle_valid", 32'(ifc.valid_flit_o), 32'd0);
    checkOutput("idle_data_hold", 32'(ifc.data_o), 32'(last_flit));
    applyStimulus(1'b0, BODY, 2'd0, 16'h0, 4'b0000);
    checkOutput("pkt_alloc_drain", 32'(is_alloc), 32'hE);
    vc_allocatable_i = 4'b0001;
    applyStimulus(1'b0, BODY, 2'd0, 16'h0, 4'b0000);
    vc_allocatable_i = 4'b0000;
    checkOutput("pkt_alloc_free", 32'(is_alloc), 32'hF);
    checkOutput("pkt_error", 32'(error), 32'h0);
    doReset();

    // HEADTAIL on VC 2: no drain wait without the check, drain wait with it.
    applyStimulus(1'b0, HEAD, 2'd0, 16'h0, 4'b0100);
    checkOutput("ht_alloc_grant_nd", 32'(is_alloc_nd), 32'hB);
    applyStimulus(1'b1, HEADTAIL, 2'd2, 16'h4444, 4'b0000);
    checkOutput("ht_alloc_nd", 32'(is_alloc_nd), 32'hF);
    checkOutput("ht_error_nd", 32'(error_nd), 32'h0);
    checkOutput("ht_alloc_drain", 32'(is_alloc), 32'hB);
    applyStimulus(1'b0, BODY, 2'd0, 16'h0, 4'b0000);
    doReset();

    // Backpressure on VC 1.
    on_off_i = 4'b1101;
    applyStimulus(1'b0, HEAD, 2'd0, 16'h0, 4'b0010);
    checkOutput("bp_on_off", 32'(is_on_off), 32'hD);
    applyStimulus(1'b1, HEAD, 2'd1, 16'h5555, 4'b0000);
    checkOutput("bp_error", 32'(error), 32'h2);
    on_off_i = 4'b1111;
    applyStimulus(1'b0, BODY, 2'd0, 16'h0, 4'b0000);
    checkOutput("bp_on_off_restore", 32'(is_on_off), 32'hF);
    checkOutput("bp_error_sticky", 32'(error), 32'h2);
    doReset();

    // Protocol errors: double grant on VC 3, body on idle VC 0.
    applyStimulus(1'b0, HEAD, 2'd0, 16'h0, 4'b1000);
    checkOutput("pe_first_grant", 32'(error), 32'h0);
    applyStimulus(1'b0, HEAD, 2'd0, 16'h0, 4'b1000);
    checkOutput("pe_double_grant", 32'(error), 32'h8);
    applyStimulus(1'b1, BODY, 2'd0, 16'h6666, 4'b0000);
    checkOutput("pe_idle_flit", 32'(error), 32'h9);
    doReset();

    // Interleaved packets on VC 0 and VC 1.
    applyStimulus(1'b0, HEAD, 2'd0, 16'h0, 4'b0011);
    checkOutput("il_alloc_grant", 32'(is_alloc), 32'hC);
    applyStimulus(1'b1, HEAD, 2'd0, 16'h7000, 4'b0000);
    applyStimulus(1'b1, HEAD, 2'd1, 16'h7100, 4'b0000);
    applyStimulus(1'b1, BODY, 2'd0, 16'h7001, 4'b0000);
    applyStimulus(1'b1, TAIL, 2'd1, 16'h7101, 4'b0000);
    checkOutput("il_alloc_tail1", 32'(is_alloc), 32'hC);
    vc_allocatable_i = 4'b0010;
    applyStimulus(1'b0, BODY, 2'd0, 16'h0, 4'b0000);
    vc_allocatable_i = 4'b0000;
    checkOutput("il_alloc_free1", 32'(is_alloc), 32'hE);
    applyStimulus(1'b1, BODY, 2'd0, 16'h7002, 4'b0000);
    checkOutput("il_alloc_vc0_active", 32'(is_alloc), 32'hE);
    checkOutput("il_error", 32'(error), 32'h0);
    applyStimulus(1'b0, BODY, 2'd0, 16'h0, 4'b0000);
    @(negedge clk);
    #1;
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
